// File: rtl/response_signature_checker.sv
// Response-side self-test checker: folds sampled DUT outputs into a Galois MISR
// and compares the final signature against a golden value.
module response_signature_checker #(
  parameter int                WIDTH          = 16,
  parameter int                SETTLE_CYCLES  = 4,
  parameter int                CAPTURE_CYCLES = 64,
  parameter logic [WIDTH-1:0]  POLY           = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0]  SEED           = WIDTH'(16'hFFFF)
) (
  input  logic             bertaClock,
  input  logic             global_reset,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  input  logic [WIDTH-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [15:0]      sample_count
);

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_COMPARE, S_DONE} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] CAP_LAST    = 16'(CAPTURE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       settle_q, settle_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] misr_next;

  assign misr_next = ((sig_q >> 1) ^ (sig_q[0] ? POLY : '0)) ^ resp_data;

  always_ff @(posedge bertaClock) begin
    if (global_reset) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      settle_q <= '0;
      pass_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    if (abort) begin
      // signature and sample_count are left alone so an aborted run can be inspected
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d  = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
            sig_d    = SEED;
            cnt_d    = '0;
            settle_d = '0;
            pass_d   = 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d  = S_CAPTURE;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        S_CAPTURE: begin
          if (resp_valid) begin
            sig_d = misr_next;
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == CAP_LAST) state_d = S_COMPARE;
          end
        end
        S_COMPARE: begin
          pass_d  = (sig_q == expected_sig);
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_SETTLE) || (state_d == S_CAPTURE) || (state_d == S_COMPARE);
    done_d = (state_d == S_DONE);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = sig_q;
  assign sample_count = cnt_q;

endmodule
